// File: rtl/nand_reduce_pipe_if.sv
// Handshake bundle for nand_reduce_pipe: the input transfer side and the result side.
interface nand_reduce_pipe_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH*CHANNELS-1:0] in_data;
    logic                      in_mode;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS-1:0]       out_y;
    logic                      out_mode;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_y, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_y, out_mode
    );
endinterface

// File: rtl/nand_reduce_pipe.sv
// Pipelined WIDTH-input NAND/AND per lane, FANIN-ary registered AND tree with global stall.
// Optional NAND_REDUCE_CNT_EN adds saturating transfer / zero-result counters.
module nand_reduce_pipe #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int FANIN    = 2
) (
    input  logic               CLK,
    input  logic               R,
    nand_reduce_pipe_if.slave  bus
`ifdef NAND_REDUCE_CNT_EN
    ,
    output logic [15:0]        xfer_cnt,
    output logic [15:0]        zero_cnt
`endif
);

    function automatic int calc_stages(int w, int f);
        int s;
        int p;
        s = 0;
        p = 1;
        while (p < w) begin
            p = p * f;
            s++;
        end
        return (s < 1) ? 1 : s;
    endfunction

    localparam int FANIN_SAFE = (FANIN == 4) ? 4 : 2;
    localparam int STAGES     = calc_stages(WIDTH, FANIN_SAFE);
    localparam int LOG2F      = (FANIN_SAFE == 4) ? 2 : 1;
    localparam int PAD_W      = 1 << (LOG2F * STAGES);

    // Bits per lane held at tree level k (level 0 is the padded input).
    function automatic int lvl_w(int k);
        return PAD_W >> (LOG2F * k);
    endfunction

    // Bit offset of level k (k >= 1) inside the packed stage register.
    function automatic int lvl_off(int k);
        int o;
        o = 0;
        for (int j = 1; j < k; j++) begin
            o += CHANNELS * lvl_w(j);
        end
        return o;
    endfunction

    localparam int TOT_W = lvl_off(STAGES + 1);

    generate
        if (WIDTH < 2 || WIDTH > 64 || CHANNELS < 1 || CHANNELS > 8 ||
            (FANIN != 2 && FANIN != 4)) begin : g_bad_param
            $error("nand_reduce_pipe: illegal WIDTH/CHANNELS/FANIN");
        end
    endgenerate

    logic                      en;
    logic [CHANNELS*PAD_W-1:0] lane_pad;
    logic [TOT_W-1:0]          lvl_q;
    logic [TOT_W-1:0]          lvl_d;
    logic [STAGES:1]           vld_q;
    logic [STAGES:1]           mode_q;
    logic [CHANNELS-1:0]       y;

    assign en           = !vld_q[STAGES] || bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = vld_q[STAGES];
    assign bus.out_mode  = mode_q[STAGES];
    assign bus.out_y     = y;

    // Leaves beyond WIDTH are tied high so they do not disturb the AND.
    always_comb begin
        lane_pad = '1;
        for (int c = 0; c < CHANNELS; c++) begin
            lane_pad[c*PAD_W +: WIDTH] = bus.in_data[c*WIDTH +: WIDTH];
        end
    end

    always_comb begin : p_tree
        logic acc;
        acc   = 1'b1;
        lvl_d = lvl_q;
        for (int k = 1; k <= STAGES; k++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i < PAD_W / FANIN_SAFE; i++) begin
                    if (i < lvl_w(k)) begin
                        acc = 1'b1;
                        for (int j = 0; j < FANIN_SAFE; j++) begin
                            if (k == 1)
                                acc = acc & lane_pad[c*PAD_W + i*FANIN_SAFE + j];
                            else
                                acc = acc & lvl_q[lvl_off(k-1) + c*lvl_w(k-1) + i*FANIN_SAFE + j];
                        end
                        lvl_d[lvl_off(k) + c*lvl_w(k) + i] = acc;
                    end
                end
            end
        end
    end

    // Whole pipeline advances or freezes together; empty slots travel as bubbles.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            lvl_q  <= '0;
            vld_q  <= '0;
            mode_q <= '0;
        end else if (en) begin
            lvl_q     <= lvl_d;
            vld_q[1]  <= bus.in_valid;
            mode_q[1] <= bus.in_valid & bus.in_mode;
            for (int k = 2; k <= STAGES; k++) begin
                vld_q[k]  <= vld_q[k-1];
                mode_q[k] <= mode_q[k-1];
            end
        end
    end

    // Result is forced low while no valid result is presented.
    always_comb begin
        y = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            y[c] = vld_q[STAGES] &
                   (mode_q[STAGES] ? lvl_q[lvl_off(STAGES) + c] : ~lvl_q[lvl_off(STAGES) + c]);
        end
    end

`ifdef NAND_REDUCE_CNT_EN
    logic out_xfer;
    assign out_xfer = bus.out_ready && vld_q[STAGES];

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            xfer_cnt <= '0;
            zero_cnt <= '0;
        end else if (out_xfer) begin
            if (xfer_cnt != 16'hFFFF)
                xfer_cnt <= xfer_cnt + 16'd1;
            if (!(&y) && zero_cnt != 16'hFFFF)
                zero_cnt <= zero_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nand_reduce_pipe.sv
// Self-checking bench for nand_reduce_pipe: an 8x2 FANIN=2 instance and a 5x2 FANIN=4 instance.
module tb_nand_reduce_pipe;
    localparam int WA = 8;
    localparam int CA = 2;
    localparam int FA = 2;
    localparam int SA = 3;
    localparam int WB = 5;
    localparam int CB = 2;
    localparam int FB = 4;
    localparam int SB = 2;

    logic clk = 1'b0;
    logic r   = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    nand_reduce_pipe_if #(.WIDTH(WA), .CHANNELS(CA)) bus_a ();
    nand_reduce_pipe_if #(.WIDTH(WB), .CHANNELS(CB)) bus_b ();

`ifdef NAND_REDUCE_CNT_EN
    logic [15:0] xfer_a, zero_a, xfer_b, zero_b;
`endif

    nand_reduce_pipe #(.WIDTH(WA), .CHANNELS(CA), .FANIN(FA)) dut_a (
        .CLK(clk), .R(r), .bus(bus_a)
`ifdef NAND_REDUCE_CNT_EN
        , .xfer_cnt(xfer_a), .zero_cnt(zero_a)
`endif
    );

    nand_reduce_pipe #(.WIDTH(WB), .CHANNELS(CB), .FANIN(FB)) dut_b (
        .CLK(clk), .R(r), .bus(bus_b)
`ifdef NAND_REDUCE_CNT_EN
        , .xfer_cnt(xfer_b), .zero_cnt(zero_b)
`endif
    );

    // Lane result: all-ones lane gives AND=1; NAND is its complement.
    function automatic logic [7:0] ref_y(logic [63:0] data, bit mode, int w, int ch);
        logic [7:0]  y;
        logic [63:0] mask;
        logic [63:0] lane;
        y    = '0;
        mask = (64'd1 << w) - 64'd1;
        for (int c = 0; c < ch; c++) begin
            lane = (data >> (c * w)) & mask;
            y[c] = mode ? (lane == mask) : (lane != mask);
        end
        return y;
    endfunction

    function automatic logic [15:0] rand_a();
        logic [15:0] d;
        for (int c = 0; c < CA; c++) begin
            d[c*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        end
        return d;
    endfunction

    task automatic test_reset();
        r = 1'b0;
        bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.in_mode = 0; bus_a.out_ready = 0;
        bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.in_mode = 0; bus_b.out_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_a got=%b exp=0", bus_a.out_valid); end
        n_tests++; if (bus_a.out_y !== 2'b00) begin n_fail++; $display("FAIL reset_out_y_a got=%b exp=00", bus_a.out_y); end
        n_tests++; if (bus_a.out_mode !== 1'b0) begin n_fail++; $display("FAIL reset_out_mode_a got=%b exp=0", bus_a.out_mode); end
        n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_a got=%b exp=1", bus_a.in_ready); end
        n_tests++; if (bus_b.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_b got=%b exp=0", bus_b.out_valid); end
        n_tests++; if (bus_b.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_b got=%b exp=1", bus_b.in_ready); end
        @(negedge clk);
        r = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got=%b exp=0", bus_a.out_valid); end
        end
    endtask

    task automatic test_nand_basic();
        logic [7:0] e;
        e = ref_y(64'hFF7F, 1'b0, WA, CA);
        @(negedge clk);
        bus_a.out_ready = 1; bus_a.in_valid = 1; bus_a.in_data = 16'hFF7F; bus_a.in_mode = 0;
        #1;
        n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got=%b exp=1", bus_a.in_ready); end
        for (int cyc = 1; cyc <= SA + 1; cyc++) begin
            @(negedge clk);
            bus_a.in_valid = 0;
            #1;
            if (cyc == SA) begin
                n_tests++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency cyc=%0d got=%b exp=1", cyc, bus_a.out_valid); end
                n_tests++; if (bus_a.out_y !== e[CA-1:0]) begin n_fail++; $display("FAIL basic_out_y got=%b exp=%b", bus_a.out_y, e[CA-1:0]); end
            end else begin
                n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid cyc=%0d got=%b exp=0", cyc, bus_a.out_valid); end
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [7:0] e1, e0;
        e1 = ref_y(64'hFFFF, 1'b1, WA, CA);
        e0 = ref_y(64'hFFFF, 1'b0, WA, CA);
        for (int cyc = 0; cyc <= SA + 2; cyc++) begin
            @(negedge clk);
            bus_a.out_ready = 1;
            bus_a.in_valid  = (cyc < 2);
            bus_a.in_data   = 16'hFFFF;
            bus_a.in_mode   = (cyc == 0);
            #1;
            if (cyc == SA) begin
                n_tests++; if (bus_a.out_valid !== 1'b1 || bus_a.out_y !== e1[CA-1:0] || bus_a.out_mode !== 1'b1) begin
                    n_fail++; $display("FAIL mode_and got v=%b y=%b m=%b exp v=1 y=%b m=1", bus_a.out_valid, bus_a.out_y, bus_a.out_mode, e1[CA-1:0]); end
            end else if (cyc == SA + 1) begin
                n_tests++; if (bus_a.out_valid !== 1'b1 || bus_a.out_y !== e0[CA-1:0] || bus_a.out_mode !== 1'b0) begin
                    n_fail++; $display("FAIL mode_nand got v=%b y=%b m=%b exp v=1 y=%b m=0", bus_a.out_valid, bus_a.out_y, bus_a.out_mode, e0[CA-1:0]); end
            end else if (cyc == SA + 2) begin
                n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL mode_tail_valid got=%b exp=0", bus_a.out_valid); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d [10];
        bit          m [10];
        logic [7:0]  e;
        int          idx;
        int          got;
        for (int i = 0; i < 10; i++) begin
            d[i] = rand_a();
            m[i] = 1'($urandom);
        end
        for (int cyc = 0; cyc <= SA + 10; cyc++) begin
            @(negedge clk);
            bus_a.out_ready = 1;
            bus_a.in_valid  = (cyc < 10);
            bus_a.in_data   = (cyc < 10) ? d[cyc] : 16'h0;
            bus_a.in_mode   = (cyc < 10) ? m[cyc] : 1'b0;
            #1;
            if (cyc >= SA && cyc < SA + 10) begin
                e = ref_y(64'(d[cyc-SA]), m[cyc-SA], WA, CA);
                n_tests++; if (bus_a.out_valid !== 1'b1 || bus_a.out_y !== e[CA-1:0] || bus_a.out_mode !== m[cyc-SA]) begin
                    n_fail++; $display("FAIL b2b_result i=%0d got v=%b y=%b m=%b exp v=1 y=%b m=%b", cyc-SA, bus_a.out_valid, bus_a.out_y, bus_a.out_mode, e[CA-1:0], m[cyc-SA]); end
            end else if (cyc == SA + 10) begin
                n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_valid got=%b exp=0", bus_a.out_valid); end
            end
        end
        // Stall with results in flight: nothing may be accepted, lost or changed.
        for (int i = 0; i < 6; i++) begin
            d[i] = rand_a();
            m[i] = 1'($urandom);
        end
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            bus_a.out_ready = !(cyc >= SA && cyc < SA + 4);
            bus_a.in_valid  = (idx < 6);
            bus_a.in_data   = (idx < 6) ? d[idx] : 16'h0;
            bus_a.in_mode   = (idx < 6) ? m[idx] : 1'b0;
            #1;
            if (cyc >= SA && cyc < SA + 4) begin
                e = ref_y(64'(d[got]), m[got], WA, CA);
                n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, bus_a.in_ready); end
                n_tests++; if (bus_a.out_valid !== 1'b1 || bus_a.out_y !== e[CA-1:0]) begin
                    n_fail++; $display("FAIL stall_hold cyc=%0d got v=%b y=%b exp v=1 y=%b", cyc, bus_a.out_valid, bus_a.out_y, e[CA-1:0]); end
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
                e = ref_y(64'(d[got]), m[got], WA, CA);
                n_tests++; if (bus_a.out_y !== e[CA-1:0] || bus_a.out_mode !== m[got]) begin
                    n_fail++; $display("FAIL stall_drain i=%0d got y=%b m=%b exp y=%b m=%b", got, bus_a.out_y, bus_a.out_mode, e[CA-1:0], m[got]); end
                got++;
            end
            if (bus_a.in_valid && bus_a.in_ready) idx++;
        end
        n_tests++; if (got != 6) begin n_fail++; $display("FAIL stall_drain_count got=%0d exp=6", got); end
        @(negedge clk);
        bus_a.in_valid = 0;
        #1;
        n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_dup got=%b exp=0", bus_a.out_valid); end
    endtask

    task automatic test_random();
        logic [7:0] qy[$];
        bit         qm[$];
        logic [7:0] e;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            bus_a.in_valid  = ($urandom_range(0, 9) < 7);
            bus_a.out_ready = ($urandom_range(0, 9) < 6);
            bus_a.in_data   = rand_a();
            bus_a.in_mode   = 1'($urandom);
            e = ref_y(64'(bus_a.in_data), bus_a.in_mode, WA, CA);
            #1;
            n_tests++; if (bus_a.in_ready !== (!bus_a.out_valid || bus_a.out_ready)) begin
                n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b ov=%b or=%b", cyc, bus_a.in_ready, bus_a.out_valid, bus_a.out_ready); end
            if (bus_a.out_valid) begin
                n_tests++;
                if (qy.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious cyc=%0d got out_valid=1 exp=0", cyc);
                end else if (bus_a.out_y !== qy[0][CA-1:0] || bus_a.out_mode !== qm[0]) begin
                    n_fail++; $display("FAIL rand_result cyc=%0d got y=%b m=%b exp y=%b m=%b", cyc, bus_a.out_y, bus_a.out_mode, qy[0][CA-1:0], qm[0]);
                end
                if (bus_a.out_ready && qy.size() != 0) begin
                    void'(qy.pop_front());
                    void'(qm.pop_front());
                end
            end
            if (bus_a.in_valid && bus_a.in_ready) begin
                qy.push_back(e);
                qm.push_back(bus_a.in_mode);
            end
        end
        for (int cyc = 0; cyc < 20 && qy.size() != 0; cyc++) begin
            @(negedge clk);
            bus_a.in_valid  = 0;
            bus_a.out_ready = 1;
            #1;
            if (bus_a.out_valid) begin
                n_tests++; if (bus_a.out_y !== qy[0][CA-1:0] || bus_a.out_mode !== qm[0]) begin
                    n_fail++; $display("FAIL rand_drain got y=%b m=%b exp y=%b m=%b", bus_a.out_y, bus_a.out_mode, qy[0][CA-1:0], qm[0]); end
                void'(qy.pop_front());
                void'(qm.pop_front());
            end
        end
        n_tests++; if (qy.size() != 0) begin n_fail++; $display("FAIL rand_lost got_remaining=%0d exp=0", qy.size()); end
    endtask

    task automatic test_padding();
        logic [9:0] d [3];
        bit         m [3];
        logic [7:0] e;
        d[0] = 10'h3FF; m[0] = 0;
        d[1] = 10'h3FE; m[1] = 0;
        d[2] = 10'h3FE; m[2] = 1;
        for (int cyc = 0; cyc <= SB + 3; cyc++) begin
            @(negedge clk);
            bus_b.out_ready = 1;
            bus_b.in_valid  = (cyc < 3);
            bus_b.in_data   = (cyc < 3) ? d[cyc] : 10'h0;
            bus_b.in_mode   = (cyc < 3) ? m[cyc] : 1'b0;
            #1;
            if (cyc >= SB && cyc < SB + 3) begin
                e = ref_y(64'(d[cyc-SB]), m[cyc-SB], WB, CB);
                n_tests++; if (bus_b.out_valid !== 1'b1 || bus_b.out_y !== e[CB-1:0] || bus_b.out_mode !== m[cyc-SB]) begin
                    n_fail++; $display("FAIL pad_result i=%0d got v=%b y=%b m=%b exp v=1 y=%b", cyc-SB, bus_b.out_valid, bus_b.out_y, bus_b.out_mode, e[CB-1:0]); end
            end else begin
                n_tests++; if (bus_b.out_valid !== 1'b0) begin n_fail++; $display("FAIL pad_valid cyc=%0d got=%b exp=0", cyc, bus_b.out_valid); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [7:0] e;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            bus_a.out_ready = 1;
            bus_a.in_valid  = 1;
            bus_a.in_data   = rand_a();
            bus_a.in_mode   = 1'($urandom);
        end
        @(negedge clk);
        bus_a.in_valid = 0;
        #1;
        n_tests++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL midflight_pre got=%b exp=1", bus_a.out_valid); end
        r = 1'b0;
        #1;
        n_tests++; if (bus_a.out_valid !== 1'b0 || bus_a.out_y !== 2'b00 || bus_a.out_mode !== 1'b0) begin
            n_fail++; $display("FAIL midflight_async got v=%b y=%b m=%b exp 0 00 0", bus_a.out_valid, bus_a.out_y, bus_a.out_mode); end
        @(negedge clk);
        r = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            #1;
            n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL midflight_ghost cyc=%0d got=%b exp=0", cyc, bus_a.out_valid); end
        end
        @(negedge clk);
        bus_a.in_valid = 1; bus_a.in_data = 16'h80FF; bus_a.in_mode = 0;
        e = ref_y(64'h80FF, 1'b0, WA, CA);
        repeat (SA) begin
            @(negedge clk);
            bus_a.in_valid = 0;
        end
        #1;
        n_tests++; if (bus_a.out_valid !== 1'b1 || bus_a.out_y !== e[CA-1:0]) begin
            n_fail++; $display("FAIL midflight_recover got v=%b y=%b exp v=1 y=%b", bus_a.out_valid, bus_a.out_y, e[CA-1:0]); end
    endtask

`ifdef NAND_REDUCE_CNT_EN
    task automatic test_counters();
        logic [15:0] d [5];
        d[0] = 16'hFF00; d[1] = 16'h1234; d[2] = 16'h00FF; d[3] = 16'h7F7F; d[4] = 16'hFE01;
        @(negedge clk);
        r = 1'b0;
        @(negedge clk);
        r = 1'b1;
        #1;
        n_tests++; if (xfer_a !== 16'd0 || zero_a !== 16'd0) begin n_fail++; $display("FAIL cnt_reset got x=%0d z=%0d exp 0 0", xfer_a, zero_a); end
        for (int cyc = 0; cyc < 5 + SA + 1; cyc++) begin
            @(negedge clk);
            bus_a.out_ready = 1;
            bus_a.in_valid  = (cyc < 5);
            bus_a.in_data   = (cyc < 5) ? d[cyc] : 16'h0;
            bus_a.in_mode   = 0;
        end
        #1;
        n_tests++; if (xfer_a !== 16'd5) begin n_fail++; $display("FAIL cnt_xfer got=%0d exp=5", xfer_a); end
        n_tests++; if (zero_a !== 16'd2) begin n_fail++; $display("FAIL cnt_zero got=%0d exp=2", zero_a); end
        for (int cyc = 0; cyc < 65540 + SA + 1; cyc++) begin
            @(negedge clk);
            bus_a.in_valid = (cyc < 65540);
            bus_a.in_data  = 16'h0000;
        end
        #1;
        n_tests++; if (xfer_a !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sat got=%h exp=FFFF", xfer_a); end
        n_tests++; if (zero_a !== 16'd2) begin n_fail++; $display("FAIL cnt_zero_hold got=%0d exp=2", zero_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_nand_basic();
        test_mode_switch();
        test_back_to_back();
        test_random();
        test_padding();
        test_reset_midflight();
`ifdef NAND_REDUCE_CNT_EN
        test_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
